// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg
// Shared types for the run-control watchdog: the FSM state encoding and the
// end-of-run cause code that is latched and presented on o_cause.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } run_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_LOOP    = 2'd1,
    CAUSE_HANG    = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } run_cause_e;

endpackage

// File: rtl/exec_watchdog_if.sv
// exec_watchdog_if
// Bundles the watchdog's control inputs, retire-monitor inputs and status
// outputs. The slave modport is the watchdog's view; the master modport is
// the view of whatever drives it (bench or FPGA top).
//   i_en, i_clr      : start request / synchronous clear
//   i_pc, i_inst_vld : retiring PC and retire strobe from the core
//   o_running/o_done : FSM status
//   o_cause          : latched end-of-run cause
//   o_cycle_cnt      : RUN cycles
//   o_retire_cnt     : retirements seen in RUN
//   o_last_pc        : PC of most recent retirement
interface exec_watchdog_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             i_en;
  logic             i_clr;
  logic [PC_W-1:0]  i_pc;
  logic             i_inst_vld;
  logic             o_running;
  logic             o_done;
  logic [1:0]       o_cause;
  logic [CNT_W-1:0] o_cycle_cnt;
  logic [CNT_W-1:0] o_retire_cnt;
  logic [PC_W-1:0]  o_last_pc;

  modport master (
    output i_en, i_clr, i_pc, i_inst_vld,
    input  o_running, o_done, o_cause, o_cycle_cnt, o_retire_cnt, o_last_pc
  );

  modport slave (
    input  i_en, i_clr, i_pc, i_inst_vld,
    output o_running, o_done, o_cause, o_cycle_cnt, o_retire_cnt, o_last_pc
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at MAX instead of wrapping. clr has priority over
// inc. The combinational next value is exported so callers can evaluate
// thresholds on the value that will be registered this edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero
//   inc        : increment request
//   cnt        : registered count
//   cnt_nxt    : value cnt takes on the next edge
module sat_counter #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && (cnt != MAX)) begin
      cnt_nxt = cnt + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/exec_watchdog.sv
// exec_watchdog
// Run-control monitor on the core's retire interface. After a start request
// it counts RUN cycles and retirements and stops (DONE) on the first of:
// a PC retiring LOOP_LIM more times in a row (self-loop halt), HANG_LIM RUN
// cycles without a retirement, or TIMEOUT_CYC RUN cycles. A zero limit
// disables that check. The cause is latched until i_clr.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : exec_watchdog_if slave view (controls, retire, status)
module exec_watchdog
  import run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned LOOP_LIM    = 8,
  parameter int unsigned HANG_LIM    = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  exec_watchdog_if.slave  bus
);

  // Loop/idle counters only need to reach their limit; keep at least 1 bit
  // so a disabled (zero) limit still elaborates.
  localparam int unsigned LOOP_W = (LOOP_LIM > 0) ? $clog2(LOOP_LIM + 1) : 1;
  localparam int unsigned IDLE_W = (HANG_LIM > 0) ? $clog2(HANG_LIM + 1) : 1;
  localparam logic [LOOP_W-1:0] LOOP_MAX = LOOP_W'(LOOP_LIM);
  localparam logic [IDLE_W-1:0] IDLE_MAX =
    (HANG_LIM > 0) ? IDLE_W'(HANG_LIM) : {IDLE_W{1'b1}};

  run_state_e state, state_nxt;
  run_cause_e cause, cause_nxt;

  logic              running;
  logic              retire;
  logic              same_pc;
  logic [PC_W-1:0]   last_pc;
  logic [CNT_W-1:0]  cycle_cnt, cycle_nxt;
  logic [CNT_W-1:0]  retire_cnt, retire_nxt;
  logic [LOOP_W-1:0] loop_cnt, loop_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic              loop_hit, hang_hit, timeout_hit;

  assign running = (state == RUN);
  assign retire  = running && bus.i_inst_vld;
  // retire_cnt != 0 keeps the very first retire of a run from matching the
  // cleared last_pc value.
  assign same_pc = retire && (bus.i_pc == last_pc) && (retire_cnt != '0);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (bus.i_clr),
    .inc     (running),
    .cnt     (cycle_cnt),
    .cnt_nxt (cycle_nxt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (bus.i_clr),
    .inc     (retire),
    .cnt     (retire_cnt),
    .cnt_nxt (retire_nxt)
  );

  // A retire at a new PC restarts the repeat run; idle cycles leave it alone.
  sat_counter #(.W(LOOP_W), .MAX(LOOP_MAX)) u_loop_cnt (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (bus.i_clr || (retire && !same_pc)),
    .inc     (same_pc),
    .cnt     (loop_cnt),
    .cnt_nxt (loop_nxt)
  );

  sat_counter #(.W(IDLE_W), .MAX(IDLE_MAX)) u_idle_cnt (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (bus.i_clr || retire),
    .inc     (running && !bus.i_inst_vld),
    .cnt     (idle_cnt),
    .cnt_nxt (idle_nxt)
  );

  // Triggers look at next-values so the stop lands on the same edge that
  // records the triggering increment.
  always_comb begin
    loop_hit    = running && (LOOP_LIM != 0) && (loop_nxt == LOOP_MAX);
    hang_hit    = running && (HANG_LIM != 0) && (idle_nxt == IDLE_W'(HANG_LIM));
    timeout_hit = running && (TIMEOUT_CYC != 0) &&
                  (64'(cycle_nxt) == 64'(TIMEOUT_CYC));
  end

  // Next-state and cause selection; clear beats everything, loop beats hang
  // beats timeout.
  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    if (bus.i_clr) begin
      state_nxt = IDLE;
      cause_nxt = CAUSE_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_en) state_nxt = RUN;
        end
        RUN: begin
          if (loop_hit) begin
            state_nxt = DONE;
            cause_nxt = CAUSE_LOOP;
          end else if (hang_hit) begin
            state_nxt = DONE;
            cause_nxt = CAUSE_HANG;
          end else if (timeout_hit) begin
            state_nxt = DONE;
            cause_nxt = CAUSE_TIMEOUT;
          end
        end
        DONE: state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cause   <= CAUSE_NONE;
      last_pc <= '0;
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
      if (bus.i_clr) begin
        last_pc <= '0;
      end else if (retire) begin
        last_pc <= bus.i_pc;
      end
    end
  end

  assign bus.o_running    = running;
  assign bus.o_done       = (state == DONE);
  assign bus.o_cause      = cause;
  assign bus.o_cycle_cnt  = cycle_cnt;
  assign bus.o_retire_cnt = retire_cnt;
  assign bus.o_last_pc    = last_pc;

endmodule

// File: tb/tb_exec_watchdog.sv
// tb_exec_watchdog
// Directed bench for exec_watchdog. Four instances cover the parameter sets
// of interest: A default limits, B TIMEOUT_CYC=100, C hang and timeout both
// 10, D 4-bit counters with every trigger disabled. Inputs change #1 after
// the rising edge and outputs are read at the same point.
module tb_exec_watchdog;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  exec_watchdog_if #(.PC_W(32), .CNT_W(32)) if_a ();
  exec_watchdog_if #(.PC_W(32), .CNT_W(32)) if_b ();
  exec_watchdog_if #(.PC_W(32), .CNT_W(32)) if_c ();
  exec_watchdog_if #(.PC_W(32), .CNT_W(4))  if_d ();

  exec_watchdog #(.PC_W(32), .CNT_W(32), .TIMEOUT_CYC(1000), .LOOP_LIM(8), .HANG_LIM(64))
    dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(if_a));
  exec_watchdog #(.PC_W(32), .CNT_W(32), .TIMEOUT_CYC(100), .LOOP_LIM(8), .HANG_LIM(64))
    dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(if_b));
  exec_watchdog #(.PC_W(32), .CNT_W(32), .TIMEOUT_CYC(10), .LOOP_LIM(8), .HANG_LIM(10))
    dut_c (.i_clk(clk), .i_rst_n(rst_n), .bus(if_c));
  exec_watchdog #(.PC_W(32), .CNT_W(4), .TIMEOUT_CYC(0), .LOOP_LIM(0), .HANG_LIM(0))
    dut_d (.i_clk(clk), .i_rst_n(rst_n), .bus(if_d));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_a.i_en = 0; if_a.i_clr = 0; if_a.i_pc = '0; if_a.i_inst_vld = 0;
    if_b.i_en = 0; if_b.i_clr = 0; if_b.i_pc = '0; if_b.i_inst_vld = 0;
    if_c.i_en = 0; if_c.i_clr = 0; if_c.i_pc = '0; if_c.i_inst_vld = 0;
    if_d.i_en = 0; if_d.i_clr = 0; if_d.i_pc = '0; if_d.i_inst_vld = 0;
    #12;
    rst_n = 1'b1;
    step();
    n_checks++; if (if_a.o_running !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_running: got %0b expected 0", if_a.o_running); end
    n_checks++; if (if_a.o_done !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_done: got %0b expected 0", if_a.o_done); end
    n_checks++; if (if_a.o_cause !== 2'd0) begin n_fails++; $display("[TB] FAIL reset_cause: got %0d expected 0", if_a.o_cause); end
    n_checks++; if (if_a.o_cycle_cnt !== 32'd0) begin n_fails++; $display("[TB] FAIL reset_cycle: got %0d expected 0", if_a.o_cycle_cnt); end
    n_checks++; if (if_a.o_retire_cnt !== 32'd0) begin n_fails++; $display("[TB] FAIL reset_retire: got %0d expected 0", if_a.o_retire_cnt); end
    n_checks++; if (if_a.o_last_pc !== 32'd0) begin n_fails++; $display("[TB] FAIL reset_last_pc: got %0h expected 0", if_a.o_last_pc); end
  endtask

  task automatic test_loop_halt();
    if_a.i_en = 1; step(); if_a.i_en = 0;
    if_a.i_inst_vld = 1;
    for (int i = 0; i < 20; i++) begin
      if_a.i_pc = 32'(4 * i);
      step();
    end
    if_a.i_pc = 32'h50;
    for (int j = 1; j <= 9; j++) begin
      step();
      if (j == 8) begin
        n_checks++; if (if_a.o_done !== 1'b0) begin n_fails++; $display("[TB] FAIL loop_early_done: got %0b expected 0", if_a.o_done); end
      end
    end
    n_checks++; if (if_a.o_done !== 1'b1) begin n_fails++; $display("[TB] FAIL loop_done: got %0b expected 1", if_a.o_done); end
    n_checks++; if (if_a.o_cause !== 2'd1) begin n_fails++; $display("[TB] FAIL loop_cause: got %0d expected 1", if_a.o_cause); end
    n_checks++; if (if_a.o_retire_cnt !== 32'd29) begin n_fails++; $display("[TB] FAIL loop_retire: got %0d expected 29", if_a.o_retire_cnt); end
    n_checks++; if (if_a.o_cycle_cnt !== 32'd29) begin n_fails++; $display("[TB] FAIL loop_cycle: got %0d expected 29", if_a.o_cycle_cnt); end
    n_checks++; if (if_a.o_last_pc !== 32'h50) begin n_fails++; $display("[TB] FAIL loop_last_pc: got %0h expected 50", if_a.o_last_pc); end
    if_a.i_pc = 32'h99;
    repeat (3) step();
    n_checks++; if (if_a.o_retire_cnt !== 32'd29) begin n_fails++; $display("[TB] FAIL loop_frozen_retire: got %0d expected 29", if_a.o_retire_cnt); end
    n_checks++; if (if_a.o_last_pc !== 32'h50) begin n_fails++; $display("[TB] FAIL loop_frozen_pc: got %0h expected 50", if_a.o_last_pc); end
    n_checks++; if (if_a.o_cause !== 2'd1) begin n_fails++; $display("[TB] FAIL loop_frozen_cause: got %0d expected 1", if_a.o_cause); end
  endtask

  task automatic test_clear_restart();
    if_a.i_clr = 1; if_a.i_en = 1; if_a.i_inst_vld = 1; if_a.i_pc = 32'h77;
    step();
    if_a.i_clr = 0; if_a.i_en = 0;
    n_checks++; if (if_a.o_done !== 1'b0 || if_a.o_running !== 1'b0) begin n_fails++; $display("[TB] FAIL clr_state: got run=%0b done=%0b expected 0 0", if_a.o_running, if_a.o_done); end
    n_checks++; if (if_a.o_cause !== 2'd0) begin n_fails++; $display("[TB] FAIL clr_cause: got %0d expected 0", if_a.o_cause); end
    n_checks++; if (if_a.o_cycle_cnt !== 32'd0 || if_a.o_retire_cnt !== 32'd0) begin n_fails++; $display("[TB] FAIL clr_counts: got cyc=%0d ret=%0d expected 0 0", if_a.o_cycle_cnt, if_a.o_retire_cnt); end
    n_checks++; if (if_a.o_last_pc !== 32'd0) begin n_fails++; $display("[TB] FAIL clr_last_pc: got %0h expected 0", if_a.o_last_pc); end
    step();
    n_checks++; if (if_a.o_running !== 1'b0 || if_a.o_retire_cnt !== 32'd0 || if_a.o_last_pc !== 32'd0) begin n_fails++; $display("[TB] FAIL idle_ignores_retire: got run=%0b ret=%0d pc=%0h expected 0 0 0", if_a.o_running, if_a.o_retire_cnt, if_a.o_last_pc); end
    if_a.i_inst_vld = 0;
    if_a.i_en = 1; step(); if_a.i_en = 0;
    n_checks++; if (if_a.o_running !== 1'b1 || if_a.o_cycle_cnt !== 32'd0) begin n_fails++; $display("[TB] FAIL restart_enter: got run=%0b cyc=%0d expected 1 0", if_a.o_running, if_a.o_cycle_cnt); end
    step();
    n_checks++; if (if_a.o_cycle_cnt !== 32'd1) begin n_fails++; $display("[TB] FAIL restart_cycle: got %0d expected 1", if_a.o_cycle_cnt); end
  endtask

  task automatic test_hang();
    if_a.i_clr = 1; step(); if_a.i_clr = 0;
    if_a.i_en = 1; step(); if_a.i_en = 0;
    if_a.i_inst_vld = 1;
    for (int i = 0; i < 5; i++) begin
      if_a.i_pc = 32'h100 + 32'(4 * i);
      step();
    end
    if_a.i_inst_vld = 0;
    repeat (63) step();
    n_checks++; if (if_a.o_done !== 1'b0) begin n_fails++; $display("[TB] FAIL hang_early_done: got %0b expected 0", if_a.o_done); end
    step();
    n_checks++; if (if_a.o_done !== 1'b1 || if_a.o_cause !== 2'd2) begin n_fails++; $display("[TB] FAIL hang_cause: got done=%0b cause=%0d expected 1 2", if_a.o_done, if_a.o_cause); end
    n_checks++; if (if_a.o_cycle_cnt !== 32'd69) begin n_fails++; $display("[TB] FAIL hang_cycle: got %0d expected 69", if_a.o_cycle_cnt); end
    n_checks++; if (if_a.o_retire_cnt !== 32'd5) begin n_fails++; $display("[TB] FAIL hang_retire: got %0d expected 5", if_a.o_retire_cnt); end
    n_checks++; if (if_a.o_last_pc !== 32'h110) begin n_fails++; $display("[TB] FAIL hang_last_pc: got %0h expected 110", if_a.o_last_pc); end
  endtask

  task automatic test_timeout();
    if_b.i_en = 1; step(); if_b.i_en = 0;
    for (int c = 1; c <= 100; c++) begin
      if_b.i_inst_vld = (c % 2 == 0);
      if_b.i_pc = 32'h1000 + 32'(4 * c);
      step();
      if (c == 99) begin
        n_checks++; if (if_b.o_done !== 1'b0) begin n_fails++; $display("[TB] FAIL timeout_early_done: got %0b expected 0", if_b.o_done); end
      end
    end
    n_checks++; if (if_b.o_done !== 1'b1 || if_b.o_cause !== 2'd3) begin n_fails++; $display("[TB] FAIL timeout_cause: got done=%0b cause=%0d expected 1 3", if_b.o_done, if_b.o_cause); end
    n_checks++; if (if_b.o_cycle_cnt !== 32'd100) begin n_fails++; $display("[TB] FAIL timeout_cycle: got %0d expected 100", if_b.o_cycle_cnt); end
    n_checks++; if (if_b.o_retire_cnt !== 32'd50) begin n_fails++; $display("[TB] FAIL timeout_retire: got %0d expected 50", if_b.o_retire_cnt); end
    if_b.i_inst_vld = 1; if_b.i_pc = 32'hdead;
    repeat (10) step();
    n_checks++; if (if_b.o_cycle_cnt !== 32'd100 || if_b.o_retire_cnt !== 32'd50) begin n_fails++; $display("[TB] FAIL timeout_frozen: got cyc=%0d ret=%0d expected 100 50", if_b.o_cycle_cnt, if_b.o_retire_cnt); end
    n_checks++; if (if_b.o_last_pc !== 32'h1190 || if_b.o_cause !== 2'd3) begin n_fails++; $display("[TB] FAIL timeout_frozen_pc: got pc=%0h cause=%0d expected 1190 3", if_b.o_last_pc, if_b.o_cause); end
    if_b.i_inst_vld = 0;
  endtask

  task automatic test_priority();
    if_c.i_en = 1; step(); if_c.i_en = 0;
    repeat (9) step();
    n_checks++; if (if_c.o_done !== 1'b0) begin n_fails++; $display("[TB] FAIL prio_early_done: got %0b expected 0", if_c.o_done); end
    step();
    n_checks++; if (if_c.o_done !== 1'b1 || if_c.o_cause !== 2'd2) begin n_fails++; $display("[TB] FAIL prio_cause: got done=%0b cause=%0d expected 1 2", if_c.o_done, if_c.o_cause); end
    n_checks++; if (if_c.o_cycle_cnt !== 32'd10) begin n_fails++; $display("[TB] FAIL prio_cycle: got %0d expected 10", if_c.o_cycle_cnt); end
  endtask

  task automatic test_saturation();
    if_d.i_en = 1; step(); if_d.i_en = 0;
    if_d.i_inst_vld = 1; if_d.i_pc = 32'h20;
    repeat (20) step();
    n_checks++; if (if_d.o_retire_cnt !== 4'd15) begin n_fails++; $display("[TB] FAIL sat_retire: got %0d expected 15", if_d.o_retire_cnt); end
    n_checks++; if (if_d.o_cycle_cnt !== 4'd15) begin n_fails++; $display("[TB] FAIL sat_cycle: got %0d expected 15", if_d.o_cycle_cnt); end
    n_checks++; if (if_d.o_running !== 1'b1 || if_d.o_done !== 1'b0) begin n_fails++; $display("[TB] FAIL sat_disabled: got run=%0b done=%0b expected 1 0", if_d.o_running, if_d.o_done); end
    n_checks++; if (if_d.o_last_pc !== 32'h20) begin n_fails++; $display("[TB] FAIL sat_last_pc: got %0h expected 20", if_d.o_last_pc); end
    if_d.i_inst_vld = 0;
  endtask

  task automatic test_async_reset();
    if_a.i_clr = 1; step(); if_a.i_clr = 0;
    if_a.i_en = 1; step(); if_a.i_en = 0;
    if_a.i_inst_vld = 1;
    for (int c = 1; c <= 37; c++) begin
      if_a.i_pc = 32'h2000 + 32'(4 * c);
      step();
    end
    n_checks++; if (if_a.o_cycle_cnt !== 32'd37 || if_a.o_running !== 1'b1) begin n_fails++; $display("[TB] FAIL arst_pre: got cyc=%0d run=%0b expected 37 1", if_a.o_cycle_cnt, if_a.o_running); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (if_a.o_running !== 1'b0 || if_a.o_done !== 1'b0 || if_a.o_cause !== 2'd0) begin n_fails++; $display("[TB] FAIL arst_status: got run=%0b done=%0b cause=%0d expected 0 0 0", if_a.o_running, if_a.o_done, if_a.o_cause); end
    n_checks++; if (if_a.o_cycle_cnt !== 32'd0 || if_a.o_retire_cnt !== 32'd0 || if_a.o_last_pc !== 32'd0) begin n_fails++; $display("[TB] FAIL arst_counts: got cyc=%0d ret=%0d pc=%0h expected 0 0 0", if_a.o_cycle_cnt, if_a.o_retire_cnt, if_a.o_last_pc); end
    #2 rst_n = 1'b1;
    if_a.i_inst_vld = 0;
    step();
    n_checks++; if (if_a.o_running !== 1'b0 || if_a.o_cycle_cnt !== 32'd0) begin n_fails++; $display("[TB] FAIL arst_idle: got run=%0b cyc=%0d expected 0 0", if_a.o_running, if_a.o_cycle_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_loop_halt();
    test_clear_restart();
    test_hang();
    test_timeout();
    test_priority();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/exec_watchdog.md
Name: exec_watchdog

Overview:
- Synthesizable run-control monitor attached to the core's debug retire interface (pc_debug / inst_vld).
- Parametrised successor to the bench's fixed-time timeout task. Counts cycles and retired instructions.
- Detects three end-of-run conditions: self-loop halt, retire hang and global timeout. Latches a cause code so the bench or FPGA top can stop the run and display the result on IO.

Parameters:
- PC_W, 32, width of the monitored PC.
- CNT_W, 32, width of the cycle and retire counters (saturating).
- TIMEOUT_CYC, 1000, RUN cycles before a timeout; 0 disables.
- LOOP_LIM, 8, consecutive same-PC retirements that count as a halt; 0 disables.
- HANG_LIM, 64, consecutive RUN cycles with no retirement that count as a hang; 0 disables.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  start request; sampled only in IDLE
- i_clr  in  1  synchronous clear; returns to IDLE from any state
- i_pc  in  PC_W  PC of the retiring instruction (core o_pc_debug)
- i_inst_vld  in  1  retire strobe (core o_inst_vld)
- o_running  out  1  state == RUN
- o_done  out  1  state == DONE
- o_cause  out  2  0 none, 1 loop-halt, 2 hang, 3 timeout
- o_cycle_cnt  out  CNT_W  cycles spent in RUN
- o_retire_cnt  out  CNT_W  retirements counted in RUN
- o_last_pc  out  PC_W  PC of the most recent retirement

Behaviour:
- Reset (async assert, sync release): state IDLE; all counters 0; o_last_pc 0; o_cause 0; o_running 0; o_done 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when i_en=1. The first RUN cycle counts as cycle 1.
  - RUN -> DONE on the first cycle any trigger fires.
  - DONE holds until i_clr.
  - i_clr=1 in any state -> IDLE next cycle. All counters, o_cause and o_last_pc clear. i_clr overrides i_en and all triggers in the same cycle.
- Counters update only in RUN.
  - o_cycle_cnt increments every RUN cycle.
  - o_retire_cnt increments when i_inst_vld=1.
  - Both saturate at 2^CNT_W-1. No wrap.
- Loop tracking (internal loop_cnt, width $clog2(LOOP_LIM+1)):
  - On a retire with i_pc == o_last_pc and retire_cnt > 0: loop_cnt increments, saturating at LOOP_LIM.
  - On a retire with a different PC, or the first retire of the run: loop_cnt = 0.
  - On cycles with no retire: loop_cnt is unchanged.
  - On every retire: o_last_pc <= i_pc.
- Hang tracking (internal idle_cnt): increments on RUN cycles without a retire and resets to 0 on a retire.
- Trigger evaluation is combinational on the current-cycle next-values:
  - loop: next loop_cnt == LOOP_LIM.
  - hang: next idle_cnt == HANG_LIM.
  - timeout: next cycle_cnt == TIMEOUT_CYC.
- Latency: o_done and o_cause become valid the cycle after the triggering edge, with state DONE registered.
- The counters include the triggering cycle's increment. Counters, o_last_pc and o_cause freeze in DONE.
- Simultaneous triggers: priority loop > hang > timeout. Only one cause is ever latched.
- A limit set to 0 disables that trigger.
- i_inst_vld and i_pc are ignored outside RUN.
- Asynchronous reset mid-RUN: immediate return to reset values. No partial state survives.

Decomposition:
- Shared package run_ctrl_pkg:
  - enum run_state_e {IDLE, RUN, DONE}
  - enum run_cause_e {CAUSE_NONE=0, CAUSE_LOOP=1, CAUSE_HANG=2, CAUSE_TIMEOUT=3}
- One sub-module is natural: sat_counter (parametrised width, enable, sync clear, saturating). It is instantiated for cycle, retire, loop and idle counting.
- FSM and trigger priority stay in exec_watchdog.

Test Plan:
- Reset, then i_en pulse, then a retire every cycle with PC 0x0, 0x4, 0x8, … for 20 cycles, then PC repeating 0x50 -> o_cause=1 and o_done=1 one cycle after the 9th retire at 0x50 (loop_cnt=8); o_last_pc=0x50, o_retire_cnt=29.
- Retire 5 instructions, then hold i_inst_vld=0 -> after 64 idle cycles o_cause=2; o_cycle_cnt=69, o_retire_cnt=5.
- Use TIMEOUT_CYC=100 with a unique PC retired every 2nd cycle -> o_cause=3 with o_cycle_cnt=100 and o_retire_cnt=50; counters stay frozen over the next 10 cycles.
- Set TIMEOUT_CYC=10 and HANG_LIM=10, and never retire -> hang and timeout fire together; o_cause=2 (priority), o_cycle_cnt=10.
- While in DONE, assert i_clr with i_en=1 -> IDLE next cycle; all outputs return to 0. A fresh i_en pulse then restarts with o_cycle_cnt=1.
- Drop i_rst_n for 3 ns in mid-RUN at cycle 37 -> outputs are 0 immediately (before the next edge) and the state is IDLE. Use CNT_W=4 with all limits 0 for 20 retires -> o_retire_cnt saturates at 15.
